// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight register writes behind decode,
// forwards the youngest ready producer per source and stalls on not-yet-valid loads.
module hazard_scoreboard #(
    parameter int DATA_W     = 32,
    parameter int RADDR_W    = 3,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dec_valid,
    input  logic                    dec_we,
    input  logic                    dec_load,
    input  logic [RADDR_W-1:0]      dec_rd,
    input  logic [RADDR_W-1:0]      dec_rs1,
    input  logic [RADDR_W-1:0]      dec_rs2,
    input  logic                    dec_use1,
    input  logic                    dec_use2,
    input  logic [DATA_W-1:0]       reg_data1,
    input  logic [DATA_W-1:0]       reg_data2,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    input  logic                    flush,
    input  logic                    freeze,
    output logic                    stall,
    output logic [DATA_W-1:0]       fwd_data1,
    output logic [DATA_W-1:0]       fwd_data2,
    output logic                    fwd_hit1,
    output logic                    fwd_hit2,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    logic [DEPTH-1:0]   v_q, v_d;
    logic [DEPTH-1:0]   we_q, we_d;
    logic [DEPTH-1:0]   ld_q, ld_d;
    logic [RADDR_W-1:0] rd_q [DEPTH];
    logic [RADDR_W-1:0] rd_d [DEPTH];
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic [RADDR_W-1:0] src_rs   [2];
    logic [1:0]         src_use;
    logic [DATA_W-1:0]  src_reg  [2];
    logic [DATA_W-1:0]  src_data [2];
    logic [1:0]         src_hit;
    logic [1:0]         src_pend;
    logic [1:0]         src_found;

    always_comb begin
        src_rs[0]  = dec_rs1;
        src_rs[1]  = dec_rs2;
        src_use    = {dec_use2, dec_use1};
        src_reg[0] = reg_data1;
        src_reg[1] = reg_data2;
    end

    // Scan from youngest (entry 0) outward; the first match shadows all older ones.
    always_comb begin
        src_hit   = '0;
        src_pend  = '0;
        src_found = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            src_data[s] = src_reg[s];
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (!src_found[s] && dec_valid && src_use[s] && v_q[k] && we_q[k]
                    && (rd_q[k] == src_rs[s])) begin
                    src_found[s] = 1'b1;
                    if (!ld_q[k] || (k >= unsigned'(LOAD_STAGE))) begin
                        src_hit[s]  = 1'b1;
                        src_data[s] = stage_data[k*DATA_W +: DATA_W];
                    end else begin
                        src_pend[s] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        stall     = |src_pend;
        fwd_hit1  = src_hit[0];
        fwd_hit2  = src_hit[1];
        fwd_data1 = src_data[0];
        fwd_data2 = src_data[1];
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

    always_comb begin
        v_d         = v_q;
        we_d        = we_q;
        ld_d        = ld_q;
        rd_d        = rd_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!freeze) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                v_d[k]  = v_q[k-1];
                we_d[k] = we_q[k-1];
                ld_d[k] = ld_q[k-1];
                rd_d[k] = rd_q[k-1];
            end
            v_d[0]  = dec_valid & ~stall & ~flush;
            we_d[0] = dec_we;
            ld_d[0] = dec_load;
            rd_d[0] = dec_rd;
            if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            we_q        <= '0;
            ld_q        <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) rd_q[k] <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            we_q        <= we_d;
            ld_q        <= ld_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic checked
// against a history-of-issued-instructions reference model.
module tb_hazard_scoreboard;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEP   = 3;
    localparam int LSTG  = 1;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            dec_valid = 1'b0, dec_we = 1'b0, dec_load = 1'b0;
    logic [AW-1:0]   dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0;
    logic            dec_use1 = 1'b0, dec_use2 = 1'b0;
    logic [DW-1:0]   reg_data1 = '0, reg_data2 = '0;
    logic [DEP*DW-1:0] stage_data = '0;
    logic            flush = 1'b0, freeze = 1'b0;
    logic            stall, fwd_hit1, fwd_hit2;
    logic [DW-1:0]   fwd_data1, fwd_data2;
    logic [CW-1:0]   stall_cnt, flush_cnt;

    hazard_scoreboard #(.DATA_W(DW), .RADDR_W(AW), .DEPTH(DEP), .LOAD_STAGE(LSTG), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_we(dec_we), .dec_load(dec_load),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use1(dec_use1), .dec_use2(dec_use2),
        .reg_data1(reg_data1), .reg_data2(reg_data2), .stage_data(stage_data),
        .flush(flush), .freeze(freeze), .stall(stall), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; bit we; bit ld; bit [AW-1:0] rd; } instr_t;
    instr_t hist[$];     // hist[k] = instruction issued k+1 slots before decode
    int     m_scnt, m_fcnt;
    int     tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        instr_t b;
        b = '{v: 1'b0, we: 1'b0, ld: 1'b0, rd: '0};
        hist.delete();
        for (int i = 0; i < DEP; i++) hist.push_back(b);
        m_scnt = 0;
        m_fcnt = 0;
    endtask

    // Youngest matching producer for one source; ready once the load has reached LOAD_STAGE.
    task automatic ref_src(input bit use_s, input bit [AW-1:0] rs,
                           output bit m, output bit rdy, output int kk);
        m = 0; rdy = 0; kk = 0;
        for (int k = 0; k < DEP; k++) begin
            if (!m && dec_valid && use_s && hist[k].v && hist[k].we && hist[k].rd == rs) begin
                m = 1; kk = k; rdy = !hist[k].ld || (k >= LSTG);
            end
        end
    endtask

    task automatic step(input bit v, input bit we, input bit ld, input bit [AW-1:0] rd,
                        input bit [AW-1:0] rs1, input bit u1, input bit [AW-1:0] rs2, input bit u2,
                        input bit fl, input bit fz, input string tag);
        bit m1, r1, m2, r2, es;
        int k1, k2;
        instr_t ni;
        logic [DW-1:0] sd [DEP];
        @(negedge clk);
        dec_valid = v; dec_we = we; dec_load = ld; dec_rd = rd;
        dec_rs1 = rs1; dec_use1 = u1; dec_rs2 = rs2; dec_use2 = u2;
        flush = fl; freeze = fz;
        reg_data1 = $urandom; reg_data2 = $urandom;
        for (int k = 0; k < DEP; k++) begin
            sd[k] = $urandom;
            stage_data[k*DW +: DW] = sd[k];
        end
        #1;
        ref_src(u1, rs1, m1, r1, k1);
        ref_src(u2, rs2, m2, r2, k2);
        es = (m1 && !r1) || (m2 && !r2);
        chk({tag, ".stall"}, DW'(stall), DW'(es));
        chk({tag, ".hit1"}, DW'(fwd_hit1), DW'(m1 && r1));
        chk({tag, ".hit2"}, DW'(fwd_hit2), DW'(m2 && r2));
        if (!m1) chk({tag, ".data1"}, fwd_data1, reg_data1);
        else if (r1) chk({tag, ".data1"}, fwd_data1, sd[k1]);
        if (!m2) chk({tag, ".data2"}, fwd_data2, reg_data2);
        else if (r2) chk({tag, ".data2"}, fwd_data2, sd[k2]);
        chk({tag, ".scnt"}, DW'(stall_cnt), DW'(m_scnt));
        chk({tag, ".fcnt"}, DW'(flush_cnt), DW'(m_fcnt));
        @(posedge clk);
        if (!fz) begin
            ni = '{v: v && !es && !fl, we: we, ld: ld, rd: rd};
            hist.push_front(ni);
            void'(hist.pop_back());
            if (es && m_scnt < CMAX) m_scnt++;
            if (fl && m_fcnt < CMAX) m_fcnt++;
        end
    endtask

    task automatic idle_inputs();
        dec_valid = 0; dec_we = 0; dec_load = 0; flush = 0; freeze = 0;
        dec_use1 = 0; dec_use2 = 0;
    endtask

    // Async pulse between edges, with decode reading a register that was in flight.
    task automatic async_reset(input string tag);
        @(negedge clk);
        idle_inputs();
        dec_valid = 1; dec_use1 = 1; dec_use2 = 1;
        #2 rst = 1'b1;
        #1;
        chk({tag, ".stall"}, DW'(stall), '0);
        chk({tag, ".hit1"}, DW'(fwd_hit1), '0);
        chk({tag, ".hit2"}, DW'(fwd_hit2), '0);
        chk({tag, ".data1"}, fwd_data1, reg_data1);
        chk({tag, ".scnt"}, DW'(stall_cnt), '0);
        chk({tag, ".fcnt"}, DW'(flush_cnt), '0);
        #1 rst = 1'b0;
        idle_inputs();
        model_reset();
    endtask

    initial begin
        model_reset();
        #12 rst = 1'b0;
        chk("reset.stall", DW'(stall), '0);
        chk("reset.scnt", DW'(stall_cnt), '0);

        // ALU forward
        step(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, "alu.issue");
        step(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, "alu.use");
        // Load-use: one stall, then forward from entry 1
        step(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, "ld.issue");
        step(1, 0, 0, 0, 2, 1, 2, 1, 0, 0, "ld.stall");
        chk("ld.stall_seen", DW'(m_scnt), DW'(1));
        step(1, 0, 0, 0, 2, 1, 2, 1, 0, 0, "ld.fwd");
        // Priority: r4 in entries 0 and 2
        step(1, 1, 0, 4, 0, 0, 0, 0, 0, 0, "pri.old");
        step(1, 1, 0, 6, 0, 0, 0, 0, 0, 0, "pri.mid");
        step(1, 1, 0, 4, 0, 0, 0, 0, 0, 0, "pri.new");
        step(1, 0, 0, 0, 4, 1, 6, 1, 0, 0, "pri.use");
        // Flush squashes the write
        step(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, "fl.squash");
        step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, "fl.use");
        // Freeze holds a load in entry 0
        step(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, "fz.ld");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 5, 1, 0, 0, 0, 1, "fz.hold");
        step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, "fz.stall");
        step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, "fz.fwd");
        // Flush together with stall
        step(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, "fs.ld");
        step(1, 1, 0, 7, 7, 1, 0, 0, 1, 0, "fs.both");
        step(1, 0, 0, 0, 7, 1, 0, 0, 0, 0, "fs.use");

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                 AW'($urandom), AW'($urandom), $urandom_range(0, 1),
                 AW'($urandom), $urandom_range(0, 1),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, "rnd");
        end

        async_reset("rst.mid");
        step(1, 0, 0, 0, 3, 1, 4, 1, 0, 0, "rst.after");

        // Self-dependent loads alternate stall / issue, driving stall_cnt to saturation
        for (int i = 0; i < 40; i++) step(1, 1, 1, 1, 1, 1, 0, 0, 0, 0, "sat");
        chk("sat.final", DW'(stall_cnt), DW'(CMAX));
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "fsat");
        chk("fsat.final", DW'(flush_cnt), DW'(CMAX));
        async_reset("rst.sat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
